delayf_tap_ctrl: RTL and testbench

//  Controller side of the DELAYF dynamic-delay interface. It drives LOADN, MOVE and DIRECTION,
//  and reads back CFLAG. A user-side REQ/ACK handshake requests an absolute tap value; the block

---
 rtl/delayf_tap_ctrl_pkg.sv | 33 +++
 rtl/delay_move_pulse.sv | 77 +++++++
 rtl/delayf_tap_ctrl.sv | 172 +++++++++++++++++
 tb/tb_delayf_tap_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delayf_tap_ctrl_pkg.sv
// Shared definitions for the DELAYF tap controller: FSM states, step
// direction encodings, default widths/presets and a small sizing helper.
package delayf_tap_ctrl_pkg;

  localparam int TAP_W_DEFAULT     = 7;
  localparam int DEL_VALUE_DEFAULT = 0;

  // DELAYF.DIRECTION encoding
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT_LOAD,
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HI,
    PH_LO
  } pulse_phase_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/delay_move_pulse.sv
// MOVE pulse generator: one start strobe produces a MOVE_HI-cycle high pulse
// followed by MOVE_LO low cycles. Also synchronises the asynchronous CFLAG.
module delay_move_pulse
  import delayf_tap_ctrl_pkg::*;
#(
  parameter int MOVE_HI = 2,
  parameter int MOVE_LO = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic cflag_i,
  output logic move_o,
  output logic fall_o,
  output logic done_o,
  output logic cflag_sync_o
);

  localparam int CNT_W = $clog2(max2(MOVE_HI, MOVE_LO) + 1);

  pulse_phase_e     phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             move_q;
  logic [1:0]       sync_q;

  // Pulse phase sequencer: high for MOVE_HI cycles, then low for MOVE_LO cycles
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      move_q  <= 1'b0;
    end else if (start_i) begin
      phase_q <= PH_HI;
      cnt_q   <= '0;
      move_q  <= 1'b1;
    end else begin
      case (phase_q)
        PH_HI: begin
          if (cnt_q == CNT_W'(MOVE_HI - 1)) begin
            phase_q <= PH_LO;
            cnt_q   <= '0;
            move_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PH_LO: begin
          if (cnt_q == CNT_W'(MOVE_LO - 1)) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Two-flop synchroniser for the cell's asynchronous CFLAG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], cflag_i};
    end
  end

  // Strobes mark the edge on which MOVE falls and the end of the low time
  assign fall_o       = (phase_q == PH_HI) && (cnt_q == CNT_W'(MOVE_HI - 1));
  assign done_o       = (phase_q == PH_LO) && (cnt_q == CNT_W'(MOVE_LO - 1));
  assign move_o       = move_q;
  assign cflag_sync_o = sync_q[1];

endmodule

// File: rtl/delayf_tap_ctrl.sv
// DELAYF dynamic-delay controller: turns an absolute tap request into LOADN
// and MOVE pulses, keeps a shadow tap count and aborts on CFLAG.
module delayf_tap_ctrl
  import delayf_tap_ctrl_pkg::*;
#(
  parameter int TAP_W     = TAP_W_DEFAULT,
  parameter int DEL_VALUE = DEL_VALUE_DEFAULT,
  parameter int LOAD_CYC  = 4,
  parameter int SETUP_CYC = 2,
  parameter int MOVE_HI   = 2,
  parameter int MOVE_LO   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             load_req_i,
  input  logic [TAP_W-1:0] target_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic [TAP_W-1:0] tap_o,
  output logic             sat_o,
  output logic             loadn_o,
  output logic             move_o,
  output logic             direction_o,
  input  logic             cflag_i
);

  localparam int               CNT_W   = $clog2(max2(LOAD_CYC, SETUP_CYC) + 1);
  localparam logic [TAP_W-1:0] DEL_TAP = TAP_W'(DEL_VALUE);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAP_W-1:0] tap_q;
  logic [TAP_W-1:0] tgt_q;
  logic             loadn_q;
  logic             dir_q;
  logic             ack_q;
  logic             busy_q;
  logic             sat_q;

  logic start_d;
  logic fall;
  logic done;
  logic cflag_sync;

  delay_move_pulse #(
    .MOVE_HI(MOVE_HI),
    .MOVE_LO(MOVE_LO)
  ) u_move_pulse (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_d),
    .cflag_i     (cflag_i),
    .move_o      (move_o),
    .fall_o      (fall),
    .done_o      (done),
    .cflag_sync_o(cflag_sync)
  );

  // Launch a MOVE pulse at the end of SETUP, or from CHECK when more steps remain
  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    start_d = 1'b0;
    if (state_q == ST_SETUP && cnt_q == CNT_W'(SETUP_CYC - 1)) begin
      start_d = 1'b1;
    end else if (state_q == ST_CHECK && tap_q != tgt_q && !cflag_sync) begin
      start_d = 1'b1;
    end
  end

  // Main controller FSM with registered handshake and cell-control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT_LOAD;
      cnt_q   <= '0;
      tap_q   <= DEL_TAP;
      tgt_q   <= '0;
      loadn_q <= 1'b0;
      dir_q   <= DIR_UP;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT_LOAD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LOAD_CYC - 1)) loadn_q <= 1'b1;
          if (cnt_q == CNT_W'(LOAD_CYC)) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (ack_q) begin
            // ACK cycle: a REQ seen here is deliberately ignored
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
          end else if (req_i && !busy_q) begin
            busy_q <= 1'b1;
            sat_q  <= 1'b0;
            tgt_q  <= target_i;
            cnt_q  <= '0;
            if (load_req_i) begin
              loadn_q <= 1'b0;
              state_q <= ST_LOAD;
            end else if (target_i == tap_q) begin
              state_q <= ST_DONE;
            end else begin
              dir_q   <= (target_i < tap_q) ? DIR_DN : DIR_UP;
              state_q <= ST_SETUP;
            end
          end
        end
        ST_LOAD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LOAD_CYC - 1)) begin
            loadn_q <= 1'b1;
            tap_q   <= DEL_TAP;
            cnt_q   <= '0;
            if (tgt_q == DEL_TAP) begin
              state_q <= ST_DONE;
            end else begin
              dir_q   <= (tgt_q < DEL_TAP) ? DIR_DN : DIR_UP;
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (start_d) begin
            cnt_q   <= '0;
            state_q <= ST_PULSE_HI;
          end
        end
        ST_PULSE_HI: begin
          // Shadow count follows the cell, which steps on the MOVE fall
          if (fall) begin
            tap_q   <= (dir_q == DIR_UP) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
            state_q <= ST_PULSE_LO;
          end
        end
        ST_PULSE_LO: begin
          if (done) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (tap_q == tgt_q) begin
            state_q <= ST_DONE;
          end else if (cflag_sync) begin
            sat_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_PULSE_HI;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign busy_o      = busy_q;
  assign tap_o       = tap_q;
  assign sat_o       = sat_q;
  assign loadn_o     = loadn_q;
  assign direction_o = dir_q;

endmodule

// File: tb/tb_delayf_tap_ctrl.sv
// Scoreboard bench for delayf_tap_ctrl: the driver predicts each request's
// outcome from the tap arithmetic and queues it; a monitor checks on ACK.
module tb_delayf_tap_ctrl;

  localparam int TAP_W     = 7;
  localparam int DEL_VALUE = 0;
  localparam int LOAD_CYC  = 4;
  localparam int SETUP_CYC = 2;
  localparam int MOVE_HI   = 2;
  localparam int MOVE_LO   = 4;
  localparam int PULSE_CYC = MOVE_HI + MOVE_LO + 1;
  localparam int MAX_WAIT  = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_i;
  logic             load_req_i;
  logic [TAP_W-1:0] target_i;
  logic             ack_o;
  logic             busy_o;
  logic [TAP_W-1:0] tap_o;
  logic             sat_o;
  logic             loadn_o;
  logic             move_o;
  logic             direction_o;
  logic             cflag_i;

  typedef struct {
    logic [TAP_W-1:0] tap;
    logic             sat;
    int               ack_cyc;
    int               pulses;
    logic             dir;
    bit               dir_valid;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_tap;

  delayf_tap_ctrl #(
    .TAP_W(TAP_W), .DEL_VALUE(DEL_VALUE), .LOAD_CYC(LOAD_CYC),
    .SETUP_CYC(SETUP_CYC), .MOVE_HI(MOVE_HI), .MOVE_LO(MOVE_LO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .load_req_i(load_req_i),
    .target_i(target_i), .ack_o(ack_o), .busy_o(busy_o), .tap_o(tap_o),
    .sat_o(sat_o), .loadn_o(loadn_o), .move_o(move_o),
    .direction_o(direction_o), .cflag_i(cflag_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles from the REQ cycle to the ACK cycle for a request that issues k pulses
  function automatic int exp_latency(input bit ld, input int k);
    int lat;
    lat = (k == 0) ? 2 : 2 + SETUP_CYC + k * PULSE_CYC;
    return ld ? lat + LOAD_CYC : lat;
  endfunction

  // Monitor: protocol invariants every cycle, scoreboard pop on every ACK
  int   mon_pulses = 0;
  int   mon_hi = 0;
  logic mon_mv = 1'b0;
  logic mon_dir = 1'b0;
  logic mon_ack = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_pulses = 0;
      mon_hi     = 0;
      mon_mv     = 1'b0;
      mon_ack    = 1'b0;
    end else begin
      check("move_while_loadn_low", {31'd0, move_o & ~loadn_o}, 0);
      if (move_o && mon_mv) check("dir_stable_during_move", direction_o, mon_dir);
      if (move_o && !mon_mv) mon_pulses++;
      if (move_o) begin
        mon_hi++;
      end else if (mon_mv) begin
        check("move_high_width", mon_hi, MOVE_HI);
        mon_hi = 0;
      end
      if (ack_o) begin
        check("ack_single_cycle", mon_ack, 0);
        check("sb_depth_at_ack", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("tap_at_ack", tap_o, e.tap);
          check("sat_at_ack", sat_o, e.sat);
          check("ack_cycle", cyc, e.ack_cyc);
          check("move_pulse_count", mon_pulses, e.pulses);
          if (e.dir_valid) check("direction", direction_o, e.dir);
        end
        mon_pulses = 0;
      end
      mon_mv  = move_o;
      mon_dir = direction_o;
      mon_ack = ack_o;
    end
  end

  // Expects rst_n low on entry; checks reset values, releases, checks INIT_LOAD timing
  task automatic release_and_check_init();
    int first_lo, first_idle;
    check("rst_loadn", loadn_o, 0);
    check("rst_move", move_o, 0);
    check("rst_ack", ack_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_sat", sat_o, 0);
    check("rst_tap", tap_o, DEL_VALUE);
    check("rst_direction", direction_o, 0);
    first_lo   = -1;
    first_idle = -1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (loadn_o && first_lo < 0) first_lo = i;
      if (!busy_o && first_idle < 0) first_idle = i;
      @(negedge clk);
    end
    check("init_loadn_low_cycles", first_lo, LOAD_CYC);
    check("init_busy_fall_cycle", first_idle, LOAD_CYC + 1);
    check("init_tap", tap_o, DEL_VALUE);
    model_tap = DEL_VALUE;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || ack_o) && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_timeout", {31'd0, busy_o | ack_o}, 0);
  endtask

  // One request; abort_k>0 raises CFLAG after the abort_k-th MOVE fall
  task automatic do_req(input int tgt, input bit ld, input int abort_k, input bit req_on_ack);
    exp_t e;
    int   start, n, k, fin, falls;
    bit   prev_mv, got_ack;
    wait_idle();
    start = ld ? DEL_VALUE : model_tap;
    n = (tgt > start) ? tgt - start : start - tgt;
    k = (abort_k > 0 && abort_k < n) ? abort_k : n;
    fin = (tgt >= start) ? start + k : start - k;
    e.tap       = TAP_W'(fin);
    e.sat       = (k < n);
    e.ack_cyc   = cyc + exp_latency(ld, k);
    e.pulses    = k;
    e.dir       = (tgt < start);
    e.dir_valid = (k > 0);
    sb_q.push_back(e);
    req_i      = 1'b1;
    target_i   = TAP_W'(tgt);
    load_req_i = ld;
    @(negedge clk);
    req_i      = 1'b0;
    load_req_i = 1'b0;
    target_i   = TAP_W'($urandom);
    check("busy_after_accept", busy_o, 1);
    check("sat_cleared_on_accept", sat_o, 0);
    falls   = 0;
    prev_mv = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < MAX_WAIT && !got_ack; i++) begin
      @(negedge clk);
      req_i      = 1'b0;
      load_req_i = 1'b0;
      if (ack_o) begin
        got_ack = 1'b1;
        if (req_on_ack) begin
          req_i      = 1'b1;
          target_i   = TAP_W'($urandom);
          load_req_i = 1'($urandom);
        end
      end else if (i == 0 && busy_o) begin
        // Request while busy: must be dropped without a second ACK
        req_i      = 1'b1;
        target_i   = TAP_W'($urandom);
        load_req_i = 1'($urandom);
      end
      if (prev_mv && !move_o) begin
        falls++;
        if (abort_k > 0 && falls == abort_k) cflag_i = 1'b1;
      end
      prev_mv = move_o;
    end
    check("ack_seen", got_ack, 1);
    if (!got_ack) sb_q.delete();
    @(negedge clk);
    req_i      = 1'b0;
    load_req_i = 1'b0;
    cflag_i    = 1'b0;
    if (got_ack) check("busy_low_after_ack", busy_o, 0);
    model_tap = fin;
  endtask

  // Reset asserted in the middle of a MOVE high phase
  task automatic reset_mid_op();
    bit seen;
    wait_idle();
    req_i      = 1'b1;
    target_i   = (model_tap < 64) ? TAP_W'(127) : TAP_W'(0);
    load_req_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = move_o;
    end
    check("move_seen_before_reset", seen, 1);
    @(posedge clk);
    #2;
    check("move_high_before_reset", move_o, 1);
    rst_n = 1'b0;
    #1;
    check("reset_move_clear", move_o, 0);
    check("reset_loadn_low", loadn_o, 0);
    check("reset_ack_clear", ack_o, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    release_and_check_init();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_i      = 1'b0;
    load_req_i = 1'b0;
    target_i   = '0;
    cflag_i    = 1'b0;
    model_tap  = DEL_VALUE;
    repeat (3) @(negedge clk);
    release_and_check_init();

    do_req(5, 1'b0, 0, 1'b0);
    do_req(2, 1'b0, 0, 1'b0);
    do_req(0, 1'b1, 0, 1'b1);
    do_req(model_tap, 1'b0, 0, 1'b0);
    do_req(127, 1'b0, 3, 1'b0);
    do_req(10, 1'b0, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      int tgt, ab;
      bit ld, roa;
      tgt = $urandom_range(0, 127);
      ld  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      roa = 1'($urandom_range(0, 1));
      do_req(tgt, ld, ab, roa);
    end

    reset_mid_op();
    do_req(20, 1'b0, 0, 1'b0);
    do_req(DEL_VALUE, 1'b1, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty_at_end", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
